// File: rtl/ws2801_pkg.sv
// Shared types and constants for the WS2801 strip driver.
package ws2801_pkg;

    localparam int BITS_PER_LED    = 24;
    localparam int WS2801_LATCH_NS = 500000;

    typedef struct packed {
        logic [7:0] red;
        logic [7:0] green;
        logic [7:0] blue;
    } rgb_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_BIT_LO,
        ST_BIT_HI,
        ST_LATCH
    } drv_state_e;

    // Bits needed for a counter that spans 0..max_count-1, never less than one.
    function automatic int cnt_width(input int max_count);
        return (max_count > 1) ? $clog2(max_count) : 1;
    endfunction

endpackage

// File: rtl/ws2801_bit_timer.sv
// Load-and-count-down timer; done_o pulses for one cycle when a loaded count expires.
module ws2801_bit_timer #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_i,
    input  logic [WIDTH-1:0] load_val_i,
    output logic             done_o
);

    logic [WIDTH-1:0] count_q;
    logic             running_q;

    // A load value of N yields done_o in the (N+1)-th cycle after the load edge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count_q   <= '0;
            running_q <= 1'b0;
        end else if (load_i) begin
            count_q   <= load_val_i;
            running_q <= 1'b1;
        end else if (running_q) begin
            if (count_q == '0) begin
                running_q <= 1'b0;
            end else begin
                count_q <= count_q - WIDTH'(1);
            end
        end
    end

    assign done_o = running_q && (count_q == '0);

endmodule

// File: rtl/ws2801_strip_driver.sv
// Streams NUM_LEDS RGB pixels MSB-first onto a WS2801 chain, then holds CKI low to latch.
module ws2801_strip_driver
    import ws2801_pkg::*;
#(
    parameter int NUM_LEDS     = 5,
    parameter int CLK_DIV      = 4,
    parameter int LATCH_CYCLES = 51000,
    parameter int STALL_MAX    = 20000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [23:0] pix_data,
    input  logic        pix_valid,
    output logic        pix_ready,
    output logic        led_sdo,
    output logic        led_cko,
    output logic        busy,
    output logic        frame_done,
    output logic        underrun
);

    localparam int TMR_MAX = (LATCH_CYCLES > CLK_DIV) ? LATCH_CYCLES : CLK_DIV;
    localparam int TMR_W   = cnt_width(TMR_MAX);
    localparam int PIX_W   = cnt_width(NUM_LEDS);
    localparam int STALL_W = cnt_width(STALL_MAX);
    localparam int BIT_W   = cnt_width(BITS_PER_LED);

    localparam logic [TMR_W-1:0]   DIV_LOAD   = TMR_W'(CLK_DIV - 1);
    localparam logic [TMR_W-1:0]   LATCH_LOAD = TMR_W'(LATCH_CYCLES - 1);
    localparam logic [PIX_W-1:0]   LAST_PIX   = PIX_W'(NUM_LEDS - 1);
    localparam logic [STALL_W-1:0] STALL_LAST = STALL_W'(STALL_MAX - 1);
    localparam logic [BIT_W-1:0]   MSB_IDX    = BIT_W'(BITS_PER_LED - 1);

    drv_state_e         state_q;
    logic [23:0]        shift_q;
    logic [BIT_W-1:0]   bit_q;
    logic [PIX_W-1:0]   pix_q;
    logic [STALL_W-1:0] stall_q;
    logic               pix_ready_q;
    logic               led_sdo_q;
    logic               led_cko_q;
    logic               busy_q;
    logic               frame_done_q;
    logic               underrun_q;

    logic               hs;
    logic               stall_hit;
    logic               last_pix;
    logic               tmr_load;
    logic [TMR_W-1:0]   tmr_val;
    logic               tmr_done;

    assign hs        = (state_q == ST_FETCH) && pix_valid && pix_ready_q;
    assign stall_hit = (state_q == ST_FETCH) && !hs && (stall_q == STALL_LAST);
    assign last_pix  = (pix_q == LAST_PIX);

    // The timer is (re)loaded on every edge that enters a timed phase.
    always_comb begin
        tmr_load = 1'b0;
        tmr_val  = DIV_LOAD;
        case (state_q)
            ST_FETCH: begin
                if (hs) begin
                    tmr_load = 1'b1;
                end else if (stall_hit) begin
                    tmr_load = 1'b1;
                    tmr_val  = LATCH_LOAD;
                end
            end
            ST_BIT_LO: tmr_load = tmr_done;
            ST_BIT_HI: begin
                if (tmr_done && (bit_q != '0)) begin
                    tmr_load = 1'b1;
                end else if (tmr_done && last_pix) begin
                    tmr_load = 1'b1;
                    tmr_val  = LATCH_LOAD;
                end
            end
            default: ;
        endcase
    end

    ws2801_bit_timer #(
        .WIDTH (TMR_W)
    ) u_timer (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_i     (tmr_load),
        .load_val_i (tmr_val),
        .done_o     (tmr_done)
    );

    // Outputs are set alongside each transition so they reflect the state being entered.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            shift_q      <= '0;
            bit_q        <= '0;
            pix_q        <= '0;
            stall_q      <= '0;
            pix_ready_q  <= 1'b0;
            led_sdo_q    <= 1'b0;
            led_cko_q    <= 1'b0;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
            underrun_q   <= 1'b0;
        end else begin
            frame_done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        state_q     <= ST_FETCH;
                        pix_q       <= '0;
                        stall_q     <= '0;
                        underrun_q  <= 1'b0;
                        pix_ready_q <= 1'b1;
                        busy_q      <= 1'b1;
                    end
                end
                ST_FETCH: begin
                    if (hs) begin
                        state_q     <= ST_BIT_LO;
                        shift_q     <= pix_data;
                        bit_q       <= MSB_IDX;
                        stall_q     <= '0;
                        pix_ready_q <= 1'b0;
                        led_sdo_q   <= pix_data[23];
                    end else if (stall_hit) begin
                        state_q     <= ST_LATCH;
                        stall_q     <= '0;
                        underrun_q  <= 1'b1;
                        pix_ready_q <= 1'b0;
                        led_sdo_q   <= 1'b0;
                    end else begin
                        stall_q <= stall_q + STALL_W'(1);
                    end
                end
                ST_BIT_LO: begin
                    if (tmr_done) begin
                        state_q   <= ST_BIT_HI;
                        led_cko_q <= 1'b1;
                    end
                end
                ST_BIT_HI: begin
                    if (tmr_done) begin
                        led_cko_q <= 1'b0;
                        if (bit_q != '0) begin
                            state_q   <= ST_BIT_LO;
                            shift_q   <= {shift_q[22:0], 1'b0};
                            bit_q     <= bit_q - BIT_W'(1);
                            led_sdo_q <= shift_q[22];
                        end else if (!last_pix) begin
                            state_q     <= ST_FETCH;
                            pix_q       <= pix_q + PIX_W'(1);
                            stall_q     <= '0;
                            pix_ready_q <= 1'b1;
                            led_sdo_q   <= 1'b0;
                        end else begin
                            state_q   <= ST_LATCH;
                            led_sdo_q <= 1'b0;
                        end
                    end
                end
                ST_LATCH: begin
                    if (tmr_done) begin
                        state_q      <= ST_IDLE;
                        busy_q       <= 1'b0;
                        frame_done_q <= 1'b1;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign pix_ready  = pix_ready_q;
    assign led_sdo    = led_sdo_q;
    assign led_cko    = led_cko_q;
    assign busy       = busy_q;
    assign frame_done = frame_done_q;
    assign underrun   = underrun_q;

endmodule
